// File: rtl/fan_pwm_driver.sv
// fan_pwm_driver
//   Fan PWM generator with spin-up kick and rate-limited duty ramping.
//   A free-running 4-bit counter defines a 16-clock PWM period. The applied
//   duty and the control state change only at period boundaries, which are
//   the edges at which the counter is 15. The exceptions are reset and
//   en_i low, which act on any edge.
//
//   Control flow:
//     IDLE -> KICK : full duty for KICK_PERIODS periods, then load the target.
//     HOLD -> RAMP : step 1 toward the target every RAMP_PERIODS periods.
//
// Ports
//   clk        in   rising-edge system clock
//   rstn       in   synchronous active-low reset
//   en_i       in   drive enable; low forces IDLE with duty 0
//   crs_i[3:0] in   target cooling rate; sampled at period boundaries only
//   pwm_o      out  PWM drive, high while period count < duty
//   duty_o[3:0] out currently applied duty (high clocks per 16)
//   ramping_o  out  high in RAMP
//   kick_o     out  high in KICK
module fan_pwm_driver #(
  parameter int KICK_PERIODS = 2,
  parameter int RAMP_PERIODS = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en_i,
  input  logic [3:0] crs_i,
  output logic       pwm_o,
  output logic [3:0] duty_o,
  output logic       ramping_o,
  output logic       kick_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_KICK = 2'd1,
    S_HOLD = 2'd2,
    S_RAMP = 2'd3
  } state_e;

  // Period-counter values at which the kick or ramp interval ends.
  // When KICK_PERIODS is 0, KICK is never entered, so KICK_LAST is unused.
  localparam logic [3:0] KICK_LAST = 4'(KICK_PERIODS - 1);
  localparam logic [3:0] RAMP_LAST = 4'(RAMP_PERIODS - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q;
  logic [3:0] duty_q, duty_d;
  logic [3:0] per_q, per_d;   // boundaries counted inside KICK or RAMP
  logic       boundary;
  logic [3:0] step_val;       // duty moved one step toward crs_i, saturating

  assign boundary = (cnt_q == 4'd15);

  always_comb begin
    step_val = duty_q;
    if (crs_i > duty_q) begin
      step_val = (duty_q == 4'd15) ? 4'd15 : duty_q + 4'd1;
    end else if (crs_i < duty_q) begin
      step_val = (duty_q == 4'd0) ? 4'd0 : duty_q - 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    per_d   = per_q;
    if (!en_i) begin
      state_d = S_IDLE;
      duty_d  = 4'd0;
      per_d   = 4'd0;
    end else if (boundary) begin
      case (state_q)
        S_IDLE: begin
          if (crs_i != 4'd0) begin
            per_d = 4'd0;
            if (KICK_PERIODS > 0) begin
              state_d = S_KICK;
              duty_d  = 4'd15;
            end else begin
              state_d = S_HOLD;
              duty_d  = crs_i;
            end
          end
        end
        S_KICK: begin
          if (per_q == KICK_LAST) begin
            per_d   = 4'd0;
            duty_d  = crs_i;
            state_d = (crs_i == 4'd0) ? S_IDLE : S_HOLD;
          end else begin
            per_d = per_q + 4'd1;
          end
        end
        S_HOLD: begin
          if (crs_i != duty_q) begin
            per_d  = 4'd0;
            duty_d = step_val;
            // A single step that already lands on the target never enters RAMP.
            if (step_val == crs_i) begin
              state_d = (step_val == 4'd0) ? S_IDLE : S_HOLD;
            end else begin
              state_d = S_RAMP;
            end
          end
        end
        S_RAMP: begin
          if (per_q == RAMP_LAST) begin
            per_d  = 4'd0;
            duty_d = step_val;
            // Reaching 0 by ramping goes straight to IDLE; no kick follows.
            if (step_val == crs_i) begin
              state_d = (step_val == 4'd0) ? S_IDLE : S_HOLD;
            end
          end else begin
            per_d = per_q + 4'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          duty_d  = 4'd0;
          per_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q   <= 4'd0;
      state_q <= S_IDLE;
      duty_q  <= 4'd0;
      per_q   <= 4'd0;
    end else begin
      cnt_q   <= cnt_q + 4'd1;
      state_q <= state_d;
      duty_q  <= duty_d;
      per_q   <= per_d;
    end
  end

  assign pwm_o     = (cnt_q < duty_q);
  assign duty_o    = duty_q;
  assign ramping_o = (state_q == S_RAMP);
  assign kick_o    = (state_q == S_KICK);

endmodule

// File: tb/tb_fan_pwm_driver.sv
// tb_fan_pwm_driver
//   Directed bench for fan_pwm_driver with the default parameters
//   (KICK_PERIODS = 2, RAMP_PERIODS = 2). Inputs are driven and outputs
//   sampled on the falling clock edge. tb_cnt tracks the expected period
//   count, restarting at 0 on each reset release.
module tb_fan_pwm_driver;

  logic       clk;
  logic       rstn;
  logic       en_i;
  logic [3:0] crs_i;
  logic       pwm_o;
  logic [3:0] duty_o;
  logic       ramping_o;
  logic       kick_o;

  int         n_checks;
  int         n_fail;
  logic [3:0] tb_cnt;

  fan_pwm_driver #(
    .KICK_PERIODS(2),
    .RAMP_PERIODS(2)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en_i     (en_i),
    .crs_i    (crs_i),
    .pwm_o    (pwm_o),
    .duty_o   (duty_o),
    .ramping_o(ramping_o),
    .kick_o   (kick_o)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (tb_cnt %0d)", tag, obs, exp, tb_cnt);
    end
  endtask

  // One clock: cross the rising edge, then return on the falling edge.
  task automatic tick();
    @(posedge clk);
    tb_cnt = tb_cnt + 4'd1;
    @(negedge clk);
  endtask

  // Advance to just after the next period boundary (at most 16 clocks),
  // then check the outputs.
  task automatic bnd(input string tag, input logic [3:0] e_duty,
                     input logic e_ramp, input logic e_kick);
    do tick(); while (tb_cnt != 4'd0);
    chk({tag, "_duty"}, 8'(duty_o), 8'(e_duty));
    chk({tag, "_ramp"}, 8'(ramping_o), 8'(e_ramp));
    chk({tag, "_kick"}, 8'(kick_o), 8'(e_kick));
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_duty,
                         input logic e_pwm, input logic e_ramp, input logic e_kick);
    chk({tag, "_duty"}, 8'(duty_o), 8'(e_duty));
    chk({tag, "_pwm"},  8'(pwm_o), 8'(e_pwm));
    chk({tag, "_ramp"}, 8'(ramping_o), 8'(e_ramp));
    chk({tag, "_kick"}, 8'(kick_o), 8'(e_kick));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    tb_cnt   = 4'd0;
    rstn     = 1'b0;
    en_i     = 1'b1;
    crs_i    = 4'd8;

    // Reset held for 3 clocks with an active request: all outputs stay low.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    end
    rstn   = 1'b1;
    crs_i  = 4'd4;
    tb_cnt = 4'd0;
    chk_all("post_reset", 4'd0, 1'b0, 1'b0, 1'b0);

    // IDLE -> KICK at the first boundary: 32 clocks at duty 15.
    bnd("kick_start", 4'd15, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) begin
      chk_all("kick", 4'd15, (tb_cnt < 4'd15), 1'b0, 1'b1);
      tick();
    end
    // Kick over: HOLD at 4, PWM high 4 of 16.
    for (int i = 0; i < 16; i++) begin
      chk_all("hold4", 4'd4, (tb_cnt < 4'd4), 1'b0, 1'b0);
      tick();
    end

    // crs_i glitches to 12 mid-period but is 8 at the boundary: ramp 4 -> 8.
    crs_i = 4'd12;
    for (int i = 0; i < 5; i++) tick();
    crs_i = 4'd8;
    bnd("up_b0", 4'd5, 1'b1, 1'b0);
    bnd("up_b1", 4'd5, 1'b1, 1'b0);
    bnd("up_b2", 4'd6, 1'b1, 1'b0);
    bnd("up_b3", 4'd6, 1'b1, 1'b0);
    bnd("up_b4", 4'd7, 1'b1, 1'b0);
    bnd("up_b5", 4'd7, 1'b1, 1'b0);
    bnd("up_b6", 4'd8, 1'b0, 1'b0);

    // Down to 6, then 6 -> 8 reversed to 4 while at duty 7.
    crs_i = 4'd6;
    bnd("dn6_b0", 4'd7, 1'b1, 1'b0);
    bnd("dn6_b1", 4'd7, 1'b1, 1'b0);
    bnd("dn6_b2", 4'd6, 1'b0, 1'b0);
    crs_i = 4'd8;
    bnd("rev_b0", 4'd7, 1'b1, 1'b0);
    crs_i = 4'd4;
    bnd("rev_b1", 4'd7, 1'b1, 1'b0);
    bnd("rev_b2", 4'd6, 1'b1, 1'b0);
    bnd("rev_b3", 4'd6, 1'b1, 1'b0);
    bnd("rev_b4", 4'd5, 1'b1, 1'b0);
    bnd("rev_b5", 4'd5, 1'b1, 1'b0);
    bnd("rev_b6", 4'd4, 1'b0, 1'b0);

    // Back up to 6, then ramp to 0 and fall into IDLE without a kick.
    crs_i = 4'd6;
    bnd("up6_b0", 4'd5, 1'b1, 1'b0);
    bnd("up6_b1", 4'd5, 1'b1, 1'b0);
    bnd("up6_b2", 4'd6, 1'b0, 1'b0);
    crs_i = 4'd0;
    bnd("off_b0",  4'd5, 1'b1, 1'b0);
    bnd("off_b1",  4'd5, 1'b1, 1'b0);
    bnd("off_b2",  4'd4, 1'b1, 1'b0);
    bnd("off_b3",  4'd4, 1'b1, 1'b0);
    bnd("off_b4",  4'd3, 1'b1, 1'b0);
    bnd("off_b5",  4'd3, 1'b1, 1'b0);
    bnd("off_b6",  4'd2, 1'b1, 1'b0);
    bnd("off_b7",  4'd2, 1'b1, 1'b0);
    bnd("off_b8",  4'd1, 1'b1, 1'b0);
    bnd("off_b9",  4'd1, 1'b1, 1'b0);
    bnd("off_b10", 4'd0, 1'b0, 1'b0);
    bnd("off_b11", 4'd0, 1'b0, 1'b0);

    // en_i low for one clock in the second kick period aborts the kick;
    // re-enabling gives a full two-period kick again.
    crs_i = 4'd6;
    bnd("k2_b0", 4'd15, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    chk_all("k2_mid", 4'd15, 1'b1, 1'b0, 1'b1);
    en_i = 1'b0;
    tick();
    chk_all("en_low", 4'd0, 1'b0, 1'b0, 1'b0);
    en_i = 1'b1;
    tick();
    chk_all("en_back", 4'd0, 1'b0, 1'b0, 1'b0);
    bnd("k3_b0", 4'd15, 1'b0, 1'b1);
    bnd("k3_b1", 4'd15, 1'b0, 1'b1);
    bnd("k3_b2", 4'd6, 1'b0, 1'b0);

    // Reset mid-ramp, then the period restarts from 0 on release.
    crs_i = 4'd2;
    bnd("r_b0", 4'd5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    rstn = 1'b0;
    tick();
    chk_all("reset_mid", 4'd0, 1'b0, 1'b0, 1'b0);
    rstn   = 1'b1;
    tb_cnt = 4'd0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk_all("rel_idle", 4'd0, 1'b0, 1'b0, 1'b0);
    end
    tick();
    chk_all("rel_kick", 4'd15, 1'b1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
